// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI-slave model of an 8-channel 12-bit serial ADC
//
// Purpose: oversamples the master's sclk/cs/din on clk, decodes the 3-bit
// channel address, fetches a sample from user logic via data_req/data_valid,
// and shifts a 16-bit frame (4 zeros + 12 sample bits, MSB first) on dout.
// Optional build macro: ADC_RESP_TESTPAT_EN replaces the user handshake with
// an internal test pattern {data_ch, frame_count[8:0]}.
//
// Ports:
//   clk, rst_n       system clock (>= 8x sclk), async active-low reset
//   sclk, cs, din    asynchronous master signals (sclk idles high, cs active low)
//   dout             serial sample data, changes after sclk falling edges
//   data_req/data_ch one-clk sample request and the channel it is for
//   data_in/valid    sample from user logic while a request is outstanding
//   addr_out         last channel address from a good frame
//   frame_done/err   one-clk frame end status pulses
//   underrun         one-clk pulse when no sample arrives in time
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_W    = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sclk,
   input  logic                cs,
   input  logic                din,
   output logic                dout,
   output logic                data_req,
   output logic [2:0]          data_ch,
   input  logic [SAMPLE_W-1:0] data_in,
   input  logic                data_valid,
   output logic [2:0]          addr_out,
   output logic                frame_done,
   output logic                frame_err,
   output logic                underrun
);

   typedef enum logic [1:0] {IDLE, WAIT_DATA, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
   logic sclk_d, cs_d;
   logic sclk_s, cs_s, din_s;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   state_t      state, state_n;
   logic [4:0]  rise_cnt, rise_cnt_n;
   logic [3:0]  fall_cnt, fall_cnt_n;
   logic [15:0] frame, frame_n;
   logic [2:0]  addr_cap, addr_cap_n;
   logic [2:0]  next_ch, next_ch_n;
   logic [2:0]  data_ch_n, addr_out_n;
   logic        dout_n, data_req_n, frame_done_n, frame_err_n, underrun_n;

`ifdef ADC_RESP_TESTPAT_EN
   logic [8:0] frame_count;
   logic       unused_handshake;
   assign unused_handshake = ^{data_in, data_valid};
`endif

   // Synchronizers reset to the idle pin levels so reset release makes no edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '1;
         cs_sync   <= '1;
         din_sync  <= '0;
         sclk_d    <= 1'b1;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign din_s     = din_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s &  sclk_d;
   assign cs_fall   = ~cs_s   &  cs_d;
   assign cs_rise   =  cs_s   & ~cs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rise_cnt   <= '0;
         fall_cnt   <= '0;
         frame      <= '0;
         addr_cap   <= '0;
         next_ch    <= '0;
         data_ch    <= '0;
         addr_out   <= '0;
         dout       <= 1'b0;
         data_req   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_n;
         rise_cnt   <= rise_cnt_n;
         fall_cnt   <= fall_cnt_n;
         frame      <= frame_n;
         addr_cap   <= addr_cap_n;
         next_ch    <= next_ch_n;
         data_ch    <= data_ch_n;
         addr_out   <= addr_out_n;
         dout       <= dout_n;
         data_req   <= data_req_n;
         frame_done <= frame_done_n;
         frame_err  <= frame_err_n;
         underrun   <= underrun_n;
      end
   end

`ifdef ADC_RESP_TESTPAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_count <= '0;
      else if (frame_done_n)
         frame_count <= frame_count + 9'd1;
   end
`endif

   always_comb begin
      state_n      = state;
      rise_cnt_n   = rise_cnt;
      fall_cnt_n   = fall_cnt;
      frame_n      = frame;
      addr_cap_n   = addr_cap;
      next_ch_n    = next_ch;
      data_ch_n    = data_ch;
      addr_out_n   = addr_out;
      dout_n       = dout;
      data_req_n   = 1'b0;
      frame_done_n = 1'b0;
      frame_err_n  = 1'b0;
      underrun_n   = 1'b0;

      case (state)
         IDLE: begin
            dout_n     = 1'b0;
            rise_cnt_n = '0;
            fall_cnt_n = '0;
            if (cs_fall) begin
               data_req_n = 1'b1;
               data_ch_n  = next_ch;
               frame_n    = '0;
               state_n    = WAIT_DATA;
            end
         end
         WAIT_DATA, SHIFT: begin
            if (cs_rise) begin
               state_n = IDLE;
               dout_n  = 1'b0;
               if (rise_cnt == 5'd16) begin
                  frame_done_n = 1'b1;
                  addr_out_n   = addr_cap;
                  next_ch_n    = addr_cap;
               end else begin
                  frame_err_n = 1'b1;
               end
            end else begin
               if (state == WAIT_DATA) begin
`ifdef ADC_RESP_TESTPAT_EN
                  frame_n[11:0] = {data_ch, frame_count};
                  state_n       = SHIFT;
`else
                  // A sample arriving on the same clk as falling edge 4 still wins.
                  if (data_valid) begin
                     frame_n[11:0] = data_in;
                     state_n       = SHIFT;
                  end else if (sclk_fall && fall_cnt == 4'd3) begin
                     underrun_n = 1'b1;
                     state_n    = SHIFT;
                  end
`endif
               end
               if (sclk_rise && rise_cnt != 5'd17) begin
                  rise_cnt_n = rise_cnt + 5'd1;
                  case (rise_cnt_n)
                     5'd3:    addr_cap_n[2] = din_s;
                     5'd4:    addr_cap_n[1] = din_s;
                     5'd5:    addr_cap_n[0] = din_s;
                     default: ;
                  endcase
               end
               // Falling edge k drives frame bit 15-k; after edge 15 dout holds.
               if (sclk_fall && fall_cnt != 4'd15) begin
                  fall_cnt_n = fall_cnt + 4'd1;
                  dout_n     = frame_n[4'd14 - fall_cnt];
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - randomized scoreboard bench for adc_spi_responder
module tb_adc_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b1;
   logic        cs = 1'b1;
   logic        din = 1'b0;
   logic        dout;
   logic        data_req;
   logic [2:0]  data_ch;
   logic [11:0] data_in = '0;
   logic        data_valid = 1'b0;
   logic [2:0]  addr_out;
   logic        frame_done;
   logic        frame_err;
   logic        underrun;

   always #5 clk = ~clk;

   adc_spi_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (sclk),
      .cs         (cs),
      .din        (din),
      .dout       (dout),
      .data_req   (data_req),
      .data_ch    (data_ch),
      .data_in    (data_in),
      .data_valid (data_valid),
      .addr_out   (addr_out),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .underrun   (underrun)
   );

   typedef struct {
      logic        good;
      logic [15:0] word;
      logic [2:0]  addr;
      int          urun;
   } frame_t;

   frame_t      exp_q[$];
   logic [2:0]  exp_ch_q[$];
   logic [15:0] got_q[$];

   int checks = 0;
   int failures = 0;

   // User-logic responder settings for the frame in flight.
   bit          supply = 1'b0;
   int          supply_delay = 0;
   logic [11:0] supply_data = '0;

   // Reference model state.
   logic [2:0] m_next_ch = '0;
   logic [2:0] m_addr_out = '0;
   logic [8:0] m_fcount = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dout"},       {31'd0, dout},       32'd0);
      check({tag, "_data_req"},   {31'd0, data_req},   32'd0);
      check({tag, "_data_ch"},    {29'd0, data_ch},    32'd0);
      check({tag, "_addr_out"},   {29'd0, addr_out},   32'd0);
      check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
      check({tag, "_underrun"},   {31'd0, underrun},   32'd0);
   endtask

   // User logic: answers each request after supply_delay clocks.
   initial begin
      forever begin
         @(negedge clk);
         if (data_req && supply) begin
            repeat (supply_delay) @(negedge clk);
            data_in    = supply_data;
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            data_in    = '0;
         end
      end
   end

   // Monitor: compares DUT pulses against the expectations queued by the master.
   initial begin
      int urun_cnt;
      frame_t e;
      logic [15:0] w;
      urun_cnt = 0;
      forever begin
         @(negedge clk);
         if (data_req) begin
            urun_cnt = 0;
            if (exp_ch_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL data_req: unexpected request ch=%0d", data_ch);
            end else begin
               check("data_ch", {29'd0, data_ch}, {29'd0, exp_ch_q.pop_front()});
            end
         end
         if (underrun) urun_cnt++;
         if (frame_done || frame_err) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL frame_end: unexpected pulse done=%0b err=%0b", frame_done, frame_err);
            end else begin
               e = exp_q.pop_front();
               w = got_q.pop_front();
               check("frame_done", {31'd0, frame_done}, {31'd0, e.good});
               check("frame_err",  {31'd0, frame_err},  {31'd0, !e.good});
               check("addr_out",   {29'd0, addr_out},   {29'd0, e.addr});
               check("underrun_count", urun_cnt, e.urun);
               if (e.good) check("dout_word", {16'd0, w}, {16'd0, e.word});
            end
         end
      end
   end

   // Master: drives one frame (SPI mode 3, sclk half period 8 clks) and
   // queues what the reference model expects. rst_after>0 pulses rst_n
   // after that rising edge and abandons the frame.
   task automatic run_frame(input logic [2:0] addr, input int nrise, input bit sup,
                            input int dly, input logic [11:0] dat, input int rst_after);
      logic [15:0] w;
      logic [2:0]  ch;
      frame_t      e;
      bit          did_rst;
      w       = '0;
      did_rst = 1'b0;
      ch      = m_next_ch;
      supply       = sup;
      supply_delay = dly;
      supply_data  = dat;
      exp_ch_q.push_back(ch);
      @(posedge clk); #1;
      cs = 1'b0;
      repeat (8) @(posedge clk); #1;
      w[15] = dout;
      for (int k = 1; k <= nrise; k++) begin
         sclk = 1'b0;
         din  = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom_range(0, 1));
         repeat (8) @(posedge clk); #1;
         if (k <= 15) w[15-k] = dout;
         sclk = 1'b1;
         repeat (8) @(posedge clk); #1;
         if (k == rst_after) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midframe_reset");
            cs   = 1'b1;
            sclk = 1'b1;
            din  = 1'b0;
            supply     = 1'b0;
            m_next_ch  = '0;
            m_addr_out = '0;
            m_fcount   = '0;
            @(posedge clk); #1;
            rst_n   = 1'b1;
            did_rst = 1'b1;
            break;
         end
      end
      if (!did_rst) begin
         e.good = (nrise == 16);
`ifdef ADC_RESP_TESTPAT_EN
         e.word = {4'h0, ch, m_fcount};
         e.urun = 0;
`else
         e.word = sup ? {4'h0, dat} : 16'h0000;
         e.urun = (!sup && nrise >= 4) ? 1 : 0;
`endif
         if (e.good) begin
            m_next_ch  = addr;
            m_addr_out = addr;
            m_fcount   = m_fcount + 9'd1;
         end
         e.addr = m_addr_out;
         got_q.push_back(w);
         exp_q.push_back(e);
         cs = 1'b1;
      end
      repeat (30) @(posedge clk);
   endtask

   initial begin
      int opts[6];
      opts = '{16, 16, 16, 2, 10, 18};
      repeat (4) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      run_frame(3'b101, 16, 1'b1, 2, 12'hA5C, 0);
      run_frame(3'b101, 16, 1'b0, 0, 12'h000, 0);
      run_frame(3'b011, 10, 1'b1, 5, 12'h123, 0);
      run_frame(3'b110, 16, 1'b1, 0, 12'h3C7, 0);
      run_frame(3'b001, 16, 1'b1, 4, 12'h555, 7);
      run_frame(3'b010, 16, 1'b1, 1, 12'hFFF, 0);
      run_frame(3'b111, 18, 1'b1, 3, 12'h0F0, 0);
      run_frame(3'b100, 2,  1'b1, 2, 12'h321, 0);
      run_frame(3'b110, 16, 1'b1, 0, 12'h800, 0);
      run_frame(3'b110, 16, 1'b1, 0, 12'h001, 0);
      run_frame(3'b110, 16, 1'b1, 0, 12'h7FE, 0);
      for (int i = 0; i < 12; i++) begin
         run_frame(3'($urandom_range(0, 7)), opts[$urandom_range(0, 5)],
                   1'($urandom_range(0, 3) != 0), $urandom_range(0, 20),
                   12'($urandom), 0);
      end

      repeat (50) @(posedge clk);
      check("pending_frames",   exp_q.size(),    0);
      check("pending_requests", exp_ch_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI-slave model of the 8-channel, 12-bit serial ADC that our ADC interface master talks to.
- Used for on-FPGA loopback and bench verification of the master without the physical converter.
- Oversamples the master's sclk/cs/din on the system clock, decodes the 3-bit channel address, and shifts a 12-bit sample out on dout.
- Fetches each sample from user logic through a request/valid handshake.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs and din before edge detection (legal values 2..3).
- SAMPLE_W, 12, sample width. The frame is always 16 bits: 4 leading zeros, then SAMPLE_W bits. Only 12 is supported.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  serial clock from the master; asynchronous to clk; idles high.
- cs  in  1  chip select from the master, active low, asynchronous.
- din  in  1  address/control bits from the master, asynchronous.
- dout  out  1  serial sample data to the master.
- data_req  out  1  one-clk pulse requesting a sample for channel data_ch.
- data_ch  out  3  channel being requested; held stable until the next data_req.
- data_in  in  12  sample value from user logic.
- data_valid  in  1  qualifies data_in while a request is outstanding.
- addr_out  out  3  last successfully received channel address.
- frame_done  out  1  one-clk pulse when a good 16-edge frame completes.
- frame_err  out  1  one-clk pulse when cs rises with a rising-edge count other than 16.
- underrun  out  1  one-clk pulse when a sample is not supplied in time.

Behaviour:
- Reset values:
  - dout=0, data_req=0, data_ch=0, addr_out=0, frame_done=0, frame_err=0, underrun=0.
  - FSM in IDLE, edge counter 0, next-channel register 0.
  - Synchronizer flops reset to cs=1, sclk=1, din=0.
- Edge detection:
  - Runs on the synchronized signals; sclk rise/fall and cs fall/rise are each one-clk strobes.
  - All reactions below occur 1 clk after the strobe, i.e. SYNC_STAGES+1 clk after the pin event.
- FSM states: IDLE, WAIT_DATA, SHIFT.
  - IDLE: dout=0, edge counter cleared. On cs fall: pulse data_req, set data_ch=next-channel register, load shift register with 16'h0000, go to WAIT_DATA.
  - WAIT_DATA: on data_valid, load shift[11:0]=data_in and go to SHIFT. If the 4th sclk falling edge arrives first: go to SHIFT with data bits 0 and pulse underrun. data_valid and data_req in the same clk is legal.
  - SHIFT: carries on shifting until cs rises.
  - In WAIT_DATA and SHIFT, a cs rise returns the FSM to IDLE and generates frame_done or frame_err (see frame end).
- Rising-edge counter:
  - Counts 1..16 and saturates at 17.
  - din is sampled on rising edges 3, 4, 5 into ADD2, ADD1, ADD0.
- Falling edges: falling edge k (k=1..15) drives dout = frame bit 15-k, MSB first. Frame bit 15 (a zero) is driven from cs fall.
- sclk edges while cs is high are ignored.
- dout after the 15th falling edge holds the last bit until cs rises, then goes to 0.
- Frame end (cs rise):
  - Count==16: pulse frame_done; addr_out and the next-channel register take the captured {ADD2,ADD1,ADD0}. The next frame therefore converts the channel addressed in the current frame.
  - Count !=16 (short or long frame): pulse frame_err; addr_out and the next-channel register are unchanged.
  - cs rise while in WAIT_DATA abandons the request; no underrun pulse.
- data_valid outside WAIT_DATA is ignored.
- Asserting rst_n low mid-frame returns the block to the reset state immediately. The following cs fall starts a fresh frame for channel 0.

Optional Feature:
- Macro: ADC_RESP_TESTPAT_EN.
- Defined:
  - data_in and data_valid are ignored; WAIT_DATA completes on the clk after entry.
  - Loaded sample = {data_ch, frame_count[8:0]}. frame_count is a 9-bit wrapping count of frame_done pulses, reset to 0.
  - data_req still pulses; underrun never asserts.
- Undefined: handshake behaviour as above. No frame counter logic is built.

Test Plan:
- Reset, then a 16-edge frame with address 3'b101, data_valid with 12'hA5C two clks after data_req:
  - dout bits read 0000_1010_0101_1100.
  - frame_done pulses once; addr_out=5.
  - Next frame's data_ch=5.
- First frame after reset: data_ch=0 on data_req regardless of the address being sent.
- No data_valid in the frame: underrun pulses once at falling edge 4; dout reads 16'h0000; frame_done still pulses.
- cs rises after 10 rising edges with address 3'b011: frame_err pulses; addr_out keeps its previous value (5); next data_ch=5.
- rst_n pulsed low after rising edge 7: all outputs reset within the same clk. A subsequent full frame with address 3'b010 and data 12'hFFF gives dout 16'h0FFF and addr_out=2.
- ADC_RESP_TESTPAT_EN defined, three back-to-back frames addressing channel 6: the second frame returns 12'hC01; the third returns 12'hC02.
